// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the FSM state encoding, the NOP instruction word, the default
// reset PC and the PC alignment helper used by the redirect path.
package if_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instructions are word aligned, so redirect targets drop their low bits.
  function automatic logic [31:0] align_pc(input logic [31:0] i_addr);
    return {i_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register for the fetch stage.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   i_adv          advance PC by 4 (wraps modulo 2^32)
//   i_redir        load the aligned redirect target (wins over i_adv)
//   i_target       redirect address, low two bits ignored
//   o_pc           current PC
module pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_adv,
  input  logic        i_redir,
  input  logic [31:0] i_target,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_redir) begin
      r_pc <= align_pc(i_target);
    end else if (i_adv) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues one instruction-memory request at a time,
// buffers the returned word for decode, and handles branch redirects,
// including redirects that arrive while a request is still outstanding.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   IsBranch, Branch_Target       redirect request and address
//   IM_Req, IM_Addr               instruction-memory request and address
//   IM_Ack, IM_Data               memory response strobe and word
//   Instr_Valid, Instr, Instr_PC  buffered instruction to decode
//   Instr_Ready                   decode accepts the buffered instruction
//
// state | meaning
// FETCH | request outstanding at PC, response will be buffered
// HOLD  | instruction buffered, waiting for decode to accept it
// DROP  | redirect seen mid-request; wait out the stale response
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IsBranch,
  input  logic [31:0] Branch_Target,
  output logic        IM_Req,
  output logic [31:0] IM_Addr,
  input  logic        IM_Ack,
  input  logic [31:0] IM_Data,
  output logic        Instr_Valid,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  input  logic        Instr_Ready
);

  if_state_e   r_state;
  if_state_e   w_next_state;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_pend;

  logic        w_adv;
  logic        w_redir;
  logic [31:0] w_redir_tgt;
  logic        w_capture;
  logic        w_discard;
  logic        w_pend_load;
  logic [31:0] w_pc;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .i_adv    (w_adv),
    .i_redir  (w_redir),
    .i_target (w_redir_tgt),
    .o_pc     (w_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_adv        = 1'b0;
    w_redir      = 1'b0;
    w_redir_tgt  = Branch_Target;
    w_capture    = 1'b0;
    w_discard    = 1'b0;
    w_pend_load  = 1'b0;
    case (r_state)
      FETCH: begin
        if (IsBranch) begin
          if (IM_Ack) begin
            // Response lands with the redirect: drop it, refetch at target.
            w_redir = 1'b1;
          end else begin
            // Keep the request stable; park the target until the ack.
            w_pend_load  = 1'b1;
            w_next_state = DROP;
          end
        end else if (IM_Ack) begin
          w_capture    = 1'b1;
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        if (IsBranch) begin
          w_redir      = 1'b1;
          w_discard    = 1'b1;
          w_next_state = FETCH;
        end else if (Instr_Ready) begin
          w_adv        = 1'b1;
          w_discard    = 1'b1;
          w_next_state = FETCH;
        end
      end
      DROP: begin
        if (IM_Ack) begin
          // A redirect in the ack cycle is newer than the parked target.
          w_redir      = 1'b1;
          w_redir_tgt  = IsBranch ? Branch_Target : r_pend;
          w_next_state = FETCH;
        end else if (IsBranch) begin
          w_pend_load = 1'b1;
        end
      end
      default: begin
        w_next_state = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_instr_pc <= 32'h0000_0000;
      r_pend     <= 32'h0000_0000;
    end else begin
      if (w_capture) begin
        r_valid    <= 1'b1;
        r_instr    <= IM_Data;
        r_instr_pc <= w_pc;
      end else if (w_discard) begin
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
      end
      if (w_pend_load) begin
        r_pend <= align_pc(Branch_Target);
      end
    end
  end

  // Request and address come from state and the PC register only, so they
  // hold steady for the whole outstanding request.
  assign IM_Req      = (r_state != HOLD);
  assign IM_Addr     = w_pc;
  assign Instr_Valid = r_valid;
  assign Instr       = r_instr;
  assign Instr_PC    = r_instr_pc;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] DWORD = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IsBranch = 1'b0;
  logic [31:0] Branch_Target = 32'h0;
  logic        IM_Req;
  logic [31:0] IM_Addr;
  logic        IM_Ack = 1'b0;
  logic [31:0] IM_Data = 32'h0;
  logic        Instr_Valid;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic        Instr_Ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: what the fetch stage is doing, in plain flags.
  logic [31:0] m_pc;
  logic        m_have;     // an instruction is sitting in the buffer
  logic        m_stale;    // outstanding response belongs to a squashed fetch
  logic [31:0] m_next_tgt;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;

  always #5 clk = ~clk;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .IsBranch      (IsBranch),
    .Branch_Target (Branch_Target),
    .IM_Req        (IM_Req),
    .IM_Addr       (IM_Addr),
    .IM_Ack        (IM_Ack),
    .IM_Data       (IM_Data),
    .Instr_Valid   (Instr_Valid),
    .Instr         (Instr),
    .Instr_PC      (Instr_PC),
    .Instr_Ready   (Instr_Ready)
  );

  task automatic model_step();
    logic [31:0] tgt;
    tgt = Branch_Target & 32'hFFFF_FFFC;
    if (rst) begin
      m_pc = RPC; m_have = 0; m_stale = 0; m_next_tgt = 0; m_instr = NOP; m_ipc = 0;
    end else if (m_have) begin
      if (IsBranch) begin
        m_have = 0; m_instr = NOP; m_pc = tgt;
      end else if (Instr_Ready) begin
        m_have = 0; m_instr = NOP; m_pc = m_pc + 32'd4;
      end
    end else if (m_stale) begin
      if (IM_Ack) begin
        m_pc = IsBranch ? tgt : m_next_tgt; m_stale = 0;
      end else if (IsBranch) begin
        m_next_tgt = tgt;
      end
    end else begin
      if (IsBranch) begin
        if (IM_Ack) m_pc = tgt;
        else begin m_stale = 1; m_next_tgt = tgt; end
      end else if (IM_Ack) begin
        m_have = 1; m_instr = IM_Data; m_ipc = m_pc;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; IsBranch = 1; Branch_Target = 32'h0000_0777; IM_Ack = 1; IM_Data = 32'h1234_5678;
    tick();
    tick();
    n_vec++; if (Instr_Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", Instr_Valid); end
    n_vec++; if (Instr !== NOP) begin n_err++; $display("FAIL reset_instr got %h exp %h", Instr, NOP); end
    n_vec++; if (Instr_PC !== 32'h0) begin n_err++; $display("FAIL reset_ipc got %h exp 0", Instr_PC); end
    rst = 0; IsBranch = 0; IM_Ack = 0;
    tick();
    n_vec++; if (IM_Req !== 1'b1) begin n_err++; $display("FAIL reset_req got %b exp 1", IM_Req); end
    n_vec++; if (IM_Addr !== RPC) begin n_err++; $display("FAIL reset_addr got %h exp %h", IM_Addr, RPC); end
  endtask

  task automatic test_sequential();
    Instr_Ready = 1;
    for (int k = 0; k < 3; k++) begin
      IM_Ack = 0;
      tick();
      IM_Ack = 1; IM_Data = DWORD;
      tick();
      IM_Ack = 0;
      n_vec++; if (Instr_Valid !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d] got %b exp 1", k, Instr_Valid); end
      n_vec++; if (Instr_PC !== 32'(k * 4)) begin n_err++; $display("FAIL seq_ipc[%0d] got %h exp %h", k, Instr_PC, 32'(k * 4)); end
      n_vec++; if (Instr !== DWORD) begin n_err++; $display("FAIL seq_instr[%0d] got %h exp %h", k, Instr, DWORD); end
      tick();
      n_vec++; if (Instr_Valid !== 1'b0) begin n_err++; $display("FAIL seq_one_cycle[%0d] got %b exp 0", k, Instr_Valid); end
      n_vec++; if (IM_Addr !== 32'((k + 1) * 4)) begin n_err++; $display("FAIL seq_addr[%0d] got %h exp %h", k, IM_Addr, 32'((k + 1) * 4)); end
    end
  endtask

  task automatic test_stall();
    IM_Ack = 1; IM_Data = 32'hCAFE_0013; Instr_Ready = 0;
    tick();
    IM_Ack = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++; if (Instr !== 32'hCAFE_0013) begin n_err++; $display("FAIL stall_instr[%0d] got %h exp cafe0013", k, Instr); end
      n_vec++; if (Instr_PC !== 32'h0000_000C) begin n_err++; $display("FAIL stall_ipc[%0d] got %h exp 0000000c", k, Instr_PC); end
      n_vec++; if (Instr_Valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %b exp 1", k, Instr_Valid); end
      n_vec++; if (IM_Req !== 1'b0) begin n_err++; $display("FAIL stall_req[%0d] got %b exp 0", k, IM_Req); end
    end
    Instr_Ready = 1;
    tick();
    n_vec++; if (IM_Addr !== 32'h0000_0010) begin n_err++; $display("FAIL stall_release_addr got %h exp 00000010", IM_Addr); end
  endtask

  task automatic test_branch_hold();
    IM_Ack = 1; IM_Data = DWORD; Instr_Ready = 0;
    tick();
    IM_Ack = 0; IsBranch = 1; Branch_Target = 32'h0000_0103;
    tick();
    IsBranch = 0; Instr_Ready = 1;
    n_vec++; if (Instr_Valid !== 1'b0) begin n_err++; $display("FAIL brhold_valid got %b exp 0", Instr_Valid); end
    n_vec++; if (IM_Addr !== 32'h0000_0100) begin n_err++; $display("FAIL brhold_addr got %h exp 00000100", IM_Addr); end
    n_vec++; if (Instr !== NOP) begin n_err++; $display("FAIL brhold_nop got %h exp %h", Instr, NOP); end
  endtask

  task automatic test_drop();
    IsBranch = 1; Branch_Target = 32'h0000_0200; IM_Ack = 0;
    tick();
    IsBranch = 0;
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (IM_Addr !== 32'h0000_0100 || IM_Req !== 1'b1) begin n_err++; $display("FAIL drop_hold_addr[%0d] got %h/%b exp 00000100/1", k, IM_Addr, IM_Req); end
      tick();
    end
    n_vec++; if (IM_Addr !== 32'h0000_0100) begin n_err++; $display("FAIL drop_last_addr got %h exp 00000100", IM_Addr); end
    IM_Ack = 1; IM_Data = 32'hDEAD_BEEF;
    tick();
    IM_Ack = 0;
    n_vec++; if (IM_Addr !== 32'h0000_0200) begin n_err++; $display("FAIL drop_resume got %h exp 00000200", IM_Addr); end
    n_vec++; if (Instr_Valid !== 1'b0) begin n_err++; $display("FAIL drop_valid got %b exp 0", Instr_Valid); end
    tick();
    n_vec++; if (Instr_Valid !== 1'b0) begin n_err++; $display("FAIL drop_valid_after got %b exp 0", Instr_Valid); end
  endtask

  task automatic test_double_drop();
    IsBranch = 1; Branch_Target = 32'h0000_0300;
    tick();
    Branch_Target = 32'h0000_0400;
    tick();
    IsBranch = 0;
    n_vec++; if (IM_Addr !== 32'h0000_0200) begin n_err++; $display("FAIL ddrop_old_addr got %h exp 00000200", IM_Addr); end
    IM_Ack = 1; IM_Data = 32'h1111_1111;
    tick();
    IM_Ack = 0;
    n_vec++; if (IM_Addr !== 32'h0000_0400) begin n_err++; $display("FAIL ddrop_newest got %h exp 00000400", IM_Addr); end
  endtask

  task automatic test_wrap_and_reset();
    IsBranch = 1; Branch_Target = 32'hFFFF_FFFF; IM_Ack = 1;
    tick();
    IsBranch = 0;
    n_vec++; if (IM_Addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_redir got %h exp fffffffc", IM_Addr); end
    IM_Data = DWORD;
    tick();
    IM_Ack = 0;
    n_vec++; if (Instr_PC !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_ipc got %h exp fffffffc", Instr_PC); end
    tick();
    n_vec++; if (IM_Addr !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_addr got %h exp 00000000", IM_Addr); end
    IM_Ack = 1;
    tick();
    IM_Ack = 0;
    tick();
    n_vec++; if (IM_Addr !== 32'h0000_0004) begin n_err++; $display("FAIL prereset_addr got %h exp 00000004", IM_Addr); end
    rst = 1; IsBranch = 1; Branch_Target = 32'h0000_0500; IM_Ack = 1;
    tick();
    rst = 0; IsBranch = 0; IM_Ack = 0;
    n_vec++; if (IM_Addr !== RPC || Instr_Valid !== 1'b0) begin n_err++; $display("FAIL midfetch_reset got %h/%b exp %h/0", IM_Addr, Instr_Valid, RPC); end
  endtask

  task automatic test_random();
    int mem_cnt;
    mem_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      IsBranch      = ($urandom_range(0, 9) == 0);
      Branch_Target = $urandom;
      Instr_Ready   = ($urandom_range(0, 9) < 7);
      IM_Ack        = 0;
      IM_Data       = $urandom;
      if (IM_Req) begin
        if (mem_cnt == 0) begin
          IM_Ack  = 1;
          mem_cnt = $urandom_range(0, 3);
        end else begin
          mem_cnt--;
        end
      end
      if (rst) mem_cnt = $urandom_range(0, 3);
      tick();
      n_vec++; if (IM_Req !== !m_have) begin n_err++; $display("FAIL rnd_req[%0d] got %b exp %b", c, IM_Req, !m_have); end
      if (!m_have) begin
        n_vec++; if (IM_Addr !== m_pc) begin n_err++; $display("FAIL rnd_addr[%0d] got %h exp %h", c, IM_Addr, m_pc); end
      end
      n_vec++; if (Instr_Valid !== m_have) begin n_err++; $display("FAIL rnd_valid[%0d] got %b exp %b", c, Instr_Valid, m_have); end
      n_vec++; if (Instr !== m_instr) begin n_err++; $display("FAIL rnd_instr[%0d] got %h exp %h", c, Instr, m_instr); end
      if (m_have) begin
        n_vec++; if (Instr_PC !== m_ipc) begin n_err++; $display("FAIL rnd_ipc[%0d] got %h exp %h", c, Instr_PC, m_ipc); end
      end
    end
    rst = 0; IsBranch = 0; IM_Ack = 0;
  endtask

  initial begin
    m_pc = RPC; m_have = 0; m_stale = 0; m_next_tgt = 0; m_instr = NOP; m_ipc = 0;
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_hold();
    test_drop();
    test_double_drop();
    test_wrap_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
